// File: rtl/cpu_pkg.sv
// cpu_pkg: types and constants shared by the CPU front end.
// The FAULT state exists only when IFETCH_ALIGN_CHECK_EN is defined.
package cpu_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

`ifdef IFETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FAULT = 2'd2
  } ifetch_state_t;
`else
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1
  } ifetch_state_t;
`endif

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with synchronous clear. DEPTH must be a power
// of two so the pointers wrap naturally. Simultaneous push and pop both take
// effect; storage is not reset, only the pointers and the occupancy count.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !clr;
  assign do_push = push && !clr && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch front end. Issues word-aligned reads at pc,
// tracks in-flight requests in a PC FIFO, pairs in-order responses with their
// PCs into a fetch queue, and hands entries to decode. flush discards queued
// and in-flight work; late responses are dropped via a discard counter.
// Optional: IFETCH_ALIGN_CHECK_EN enables misaligned-PC detection (FAULT
// state presenting a NOP at the faulting pc until flushed).
// QDEPTH must be a power of two, at least 2.
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] pc,
  output logic            pc_write,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  input  logic [XLEN-1:0] mem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  input  logic            flush
);

  localparam int CW = $clog2(QDEPTH) + 1;

  ifetch_state_t     state;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     discard;

  logic              accept;
  logic              pc_ok;
  logic              credit_ok;
  logic [CW:0]       occupancy;
  logic              rsp_keep;
  logic              rsp_drop;
  logic              rsp_any;
  logic              q_valid;
  logic              q_pop;
  logic              nop_valid;

  logic [XLEN-1:0]   pcf_head;
  logic              pcf_empty;
  logic [2*XLEN-1:0] q_head;
  logic              q_empty;
  logic [CW-1:0]     q_count;

  logic              unused_pcf_full;
  logic              unused_pcf_empty;
  logic              unused_q_full;
  logic [CW-1:0]     unused_pcf_count;

`ifdef IFETCH_ALIGN_CHECK_EN
  assign pc_ok = (pc[1:0] == 2'b00);
`else
  assign pc_ok = 1'b1;
`endif

  // Credit counts the entry leaving the queue this cycle, so a 1-cycle memory
  // with a ready consumer sustains one request per cycle without overflow.
  assign q_valid   = rst_n && !q_empty;
  assign q_pop     = q_valid && inst_ready;
  assign occupancy = {1'b0, q_count} - (CW+1)'(q_pop) + {1'b0, inflight};
  assign credit_ok = occupancy < (CW+1)'(QDEPTH);

  assign mem_req_valid = rst_n && (state == ST_RUN) && !flush && credit_ok && pc_ok;
  assign mem_req_addr  = {pc[XLEN-1:2], 2'b00};
  assign accept        = mem_req_valid && mem_req_ready;
  assign pc_write      = accept;

  // Responses belong to the oldest outstanding request: discarded ones first.
  assign rsp_drop = mem_rsp_valid && (discard != '0);
  assign rsp_keep = mem_rsp_valid && (discard == '0) && !flush;
  assign rsp_any  = mem_rsp_valid && ((discard != '0) || (inflight != '0));

`ifdef IFETCH_ALIGN_CHECK_EN
  assign nop_valid = rst_n && (state == ST_FAULT) && q_empty && (inflight == '0);
`else
  assign nop_valid = 1'b0;
`endif

  assign inst_valid = q_valid || nop_valid;

  // Decode-side data; zero whenever nothing is presented
  always_comb begin
    inst_data = '0;
    inst_pc   = '0;
    if (q_valid) begin
      inst_data = q_head[2*XLEN-1:XLEN];
      inst_pc   = q_head[XLEN-1:0];
    end else if (nop_valid) begin
      inst_data = INSTR_NOP;
      inst_pc   = pc;
    end
  end

  // In-flight and discard counters; flush turns all in-flight work into discards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
      discard  <= '0;
    end else if (flush) begin
      inflight <= '0;
      discard  <= discard + inflight - CW'(rsp_any);
    end else begin
      inflight <= inflight + CW'(accept) - CW'(rsp_keep);
      discard  <= discard - CW'(rsp_drop);
    end
  end

  // Control FSM: RUN issues, DRAIN waits out discarded responses, FAULT holds a NOP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (flush && (inflight != '0)) state <= ST_DRAIN;
`ifdef IFETCH_ALIGN_CHECK_EN
          else if (!flush && !pc_ok)     state <= ST_FAULT;
`endif
        end
        ST_DRAIN: begin
          if (!flush && (discard == '0)) state <= ST_RUN;
        end
`ifdef IFETCH_ALIGN_CHECK_EN
        ST_FAULT: begin
          if (flush) state <= (inflight != '0) ? ST_DRAIN : ST_RUN;
        end
`endif
        default: state <= ST_RUN;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (XLEN),
    .DEPTH (QDEPTH)
  ) u_pc_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (accept),
    .wdata (mem_req_addr),
    .pop   (rsp_keep),
    .rdata (pcf_head),
    .empty (pcf_empty),
    .full  (unused_pcf_full),
    .count (unused_pcf_count)
  );

  assign unused_pcf_empty = pcf_empty;

  sync_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (QDEPTH)
  ) u_fetch_q (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (flush),
    .push  (rsp_keep),
    .wdata ({mem_rsp_data, pcf_head}),
    .pop   (q_pop),
    .rdata (q_head),
    .empty (q_empty),
    .full  (unused_q_full),
    .count (q_count)
  );

endmodule
